// File: rtl/rf_write_arbiter_if.sv
// Register-file write arbiter bus: the two producer request channels, the
// arbitrated register-file write port and the pending-write mask.
interface rf_write_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic [31:0] busy_mask;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, rf_src, busy_mask
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, rf_src, busy_mask
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port between the pipeline (A) and a buffered
// long-latency unit (B). RF_ARB_STARVE_GUARD_EN enables the B anti-starvation guard.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave arb
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be >= 1");
    end

    logic [4:0]            addr_q [FIFO_DEPTH];
    logic [31:0]           data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic        rf_we_q, rf_we_d, rf_src_q, rf_src_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [31:0] busy;

    logic empty, full, push, pop, force_b, grant_a, grant_b;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(FIFO_DEPTH));

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] scnt_q, scnt_d;

    // Counts A grants that overtook a waiting B entry; saturates at the limit.
    assign force_b = (scnt_q == SW'(STARVE_LIMIT)) && !empty;

    always_comb begin
        scnt_d = scnt_q;
        if (grant_b || empty)
            scnt_d = '0;
        else if (grant_a && scnt_q != SW'(STARVE_LIMIT))
            scnt_d = scnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) scnt_q <= '0;
        else      scnt_q <= scnt_d;
    end
`else
    assign force_b = 1'b0;
`endif

    assign arb.a_ready = rst && !force_b;
    assign arb.b_ready = rst && !full;

    assign grant_a = arb.a_valid && arb.a_ready;
    assign grant_b = rst && !grant_a && !empty;
    assign push    = arb.b_valid && arb.b_ready;
    assign pop     = grant_b;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_src_d   = rf_src_q;
        if (grant_a) begin
            rf_we_d    = (arb.a_addr != 5'd0);
            rf_waddr_d = arb.a_addr;
            rf_wdata_d = arb.a_data;
            rf_src_d   = 1'b0;
        end else if (grant_b) begin
            rf_we_d    = (addr_q[rd_ptr_q] != 5'd0);
            rf_waddr_d = addr_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
            rf_src_d   = 1'b1;
        end
    end

    // Push and pop never alias: a push needs a free slot, a pop needs a filled one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= arb.b_addr;
                data_q[wr_ptr_q] <= arb.b_data;
                vld_q[wr_ptr_q]  <= 1'b1;
            end
            if (pop)
                vld_q[rd_ptr_q] <= 1'b0;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_src_q   <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_q   <= rf_src_d;
        end
    end

    // r0 is never a hazard, so queued r0 writes do not mark it busy.
    always_comb begin
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (vld_q[i] && addr_q[i] != 5'd0)
                busy[addr_q[i]] = 1'b1;
    end

    assign arb.busy_mask = busy;
    assign arb.rf_we     = rf_we_q;
    assign arb.rf_waddr  = rf_waddr_q;
    assign arb.rf_wdata  = rf_wdata_q;
    assign arb.rf_src    = rf_src_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued in grant
// order as stimulus is driven and matched against every rf_we pulse.
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] sb[$];

    rf_write_arbiter_if bus();

    rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .arb(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wr(input logic [4:0] a, input logic [31:0] d, input logic s);
        return {26'd0, a, d, s};
    endfunction

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv_a(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.a_valid = v; bus.a_addr = a; bus.a_data = d;
    endtask

    task automatic drv_b(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.b_valid = v; bus.b_addr = a; bus.b_data = d;
    endtask

    // Every register-file write must be the next one the scoreboard expects.
    always @(negedge clk) begin
        if (rst && bus.rf_we) begin
            if (sb.size() == 0)
                chk("unexp_wr", wr(bus.rf_waddr, bus.rf_wdata, bus.rf_src), 64'd0);
            else
                chk("wr", wr(bus.rf_waddr, bus.rf_wdata, bus.rf_src), sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        drv_a(1'b0, 5'd0, 32'd0);
        drv_b(1'b0, 5'd0, 32'd0);
        repeat (2) nxt();
        mid();
        chk("rst_ardy", bus.a_ready, 1'b0);
        chk("rst_brdy", bus.b_ready, 1'b0);
        chk("rst_we", bus.rf_we, 1'b0);
        chk("rst_out", wr(bus.rf_waddr, bus.rf_wdata, bus.rf_src), 64'd0);
        chk("rst_busy", bus.busy_mask, 32'd0);

        nxt(); rst = 1'b1;
        mid();
        chk("idle_we", bus.rf_we, 1'b0);
        chk("idle_busy", bus.busy_mask, 32'd0);
        chk("idle_ardy", bus.a_ready, 1'b1);
        chk("idle_brdy", bus.b_ready, 1'b1);

        // A only: one-cycle latency
        nxt(); drv_a(1'b1, 5'd5, 32'hDEADBEEF); sb.push_back(wr(5'd5, 32'hDEADBEEF, 1'b0));
        mid(); chk("a_rdy", bus.a_ready, 1'b1);
        nxt(); drv_a(1'b0, 5'd0, 32'd0);
        mid(); chk("a_lat", bus.rf_we, 1'b1); chk("a_src", bus.rf_src, 1'b0);
        nxt(); mid(); chk("a_we_off", bus.rf_we, 1'b0);

        // B latency and busy_mask
        nxt(); drv_b(1'b1, 5'd9, 32'h1234); sb.push_back(wr(5'd9, 32'h1234, 1'b1));
        mid();
        nxt(); drv_b(1'b0, 5'd0, 32'd0);
        mid(); chk("b_busy_set", bus.busy_mask, 32'h1 << 9); chk("b_we_early", bus.rf_we, 1'b0);
        nxt();
        mid(); chk("b_lat", bus.rf_we, 1'b1); chk("b_src", bus.rf_src, 1'b1);
        chk("b_busy_clr", bus.busy_mask, 32'd0);

`ifndef RF_ARB_STARVE_GUARD_EN
        // FIFO full under strict A priority
        nxt(); drv_a(1'b1, 5'd1, 32'd100); drv_b(1'b1, 5'd10, 32'hA0); sb.push_back(wr(5'd1, 32'd100, 1'b0));
        mid(); chk("full_brdy0", bus.b_ready, 1'b1);
        nxt(); drv_a(1'b1, 5'd2, 32'd101); drv_b(1'b1, 5'd11, 32'hA1); sb.push_back(wr(5'd2, 32'd101, 1'b0));
        mid(); chk("full_brdy1", bus.b_ready, 1'b1);
        nxt(); drv_a(1'b1, 5'd3, 32'd102); drv_b(1'b1, 5'd12, 32'hA2); sb.push_back(wr(5'd3, 32'd102, 1'b0));
        mid(); chk("full_brdy2", bus.b_ready, 1'b0);
        chk("full_busy", bus.busy_mask, (32'h1 << 10) | (32'h1 << 11));
        nxt(); drv_a(1'b0, 5'd0, 32'd0);
        sb.push_back(wr(5'd10, 32'hA0, 1'b1));
        sb.push_back(wr(5'd11, 32'hA1, 1'b1));
        sb.push_back(wr(5'd12, 32'hA2, 1'b1));
        mid(); chk("full_pop_brdy", bus.b_ready, 1'b0);
        nxt();
        mid(); chk("refill_brdy", bus.b_ready, 1'b1);
        nxt(); drv_b(1'b0, 5'd0, 32'd0);
        repeat (3) nxt();
        mid(); chk("full_drain_busy", bus.busy_mask, 32'd0);
`else
        // Starvation guard: B forced after STARVE_LIMIT overtaking A grants
        for (int i = 0; i < 5; i++) begin
            nxt();
            drv_a(1'b1, 5'(20 + i), 32'(200 + i));
            drv_b(i == 0, 5'd15, 32'h55);
            sb.push_back(wr(5'(20 + i), 32'(200 + i), 1'b0));
            mid(); chk("starve_ardy", bus.a_ready, 1'b1);
        end
        nxt(); drv_a(1'b1, 5'd25, 32'd225); sb.push_back(wr(5'd15, 32'h55, 1'b1));
        mid(); chk("force_b", bus.a_ready, 1'b0);
        nxt(); sb.push_back(wr(5'd25, 32'd225, 1'b0));
        mid(); chk("a_resume", bus.a_ready, 1'b1);
        nxt(); drv_a(1'b0, 5'd0, 32'd0);
        repeat (2) nxt();
        mid(); chk("starve_busy", bus.busy_mask, 32'd0);
`endif

        // r0 write consumes the grant but never writes
        nxt(); drv_a(1'b1, 5'd0, 32'h77);
        mid(); chk("r0_ardy", bus.a_ready, 1'b1);
        nxt(); drv_a(1'b0, 5'd0, 32'd0);
        mid(); chk("r0_we", bus.rf_we, 1'b0); chk("r0_wdata", bus.rf_wdata, 32'h77);

        // Async reset with two B entries queued behind A
        nxt(); drv_a(1'b1, 5'd7, 32'h70); drv_b(1'b1, 5'd16, 32'hB6); sb.push_back(wr(5'd7, 32'h70, 1'b0));
        nxt(); drv_a(1'b1, 5'd8, 32'h80); drv_b(1'b1, 5'd17, 32'hB7); sb.push_back(wr(5'd8, 32'h80, 1'b0));
        mid(); chk("pre_rst_busy", bus.busy_mask, 32'h1 << 16);
        nxt(); drv_a(1'b1, 5'd9, 32'h90); drv_b(1'b0, 5'd0, 32'd0);
        mid(); chk("pre_rst_we", bus.rf_we, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_we", bus.rf_we, 1'b0);
        chk("arst_out", wr(bus.rf_waddr, bus.rf_wdata, bus.rf_src), 64'd0);
        chk("arst_busy", bus.busy_mask, 32'd0);
        chk("arst_ardy", bus.a_ready, 1'b0);
        chk("arst_brdy", bus.b_ready, 1'b0);
        drv_a(1'b0, 5'd0, 32'd0);
        repeat (2) nxt();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mid(); chk("post_rst_we", bus.rf_we, 1'b0);
            nxt();
        end
        chk("post_rst_busy", bus.busy_mask, 32'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (addr/data/enable) between two producers.
  - Requester A: in-order pipeline writeback.
  - Requester B: long-latency unit (multiply/divide, late loads).
- Buffers B writes in a small FIFO, arbitrates each cycle and drives the register-file write port from a registered output stage.
- Exports a pending-write mask so hazard logic can stall readers of registers with queued B writes.

Parameters:
- FIFO_DEPTH, 2, B-side buffer entries; power of 2, >=2.
- STARVE_LIMIT, 4, consecutive A grants with B pending before B is forced; >=1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- a_valid  in  1  A write request
- a_addr  in  5  A destination register
- a_data  in  32  A write data
- a_ready  out  1  A accepted this cycle when a_valid&&a_ready
- b_valid  in  1  B write request
- b_addr  in  5  B destination register
- b_data  in  32  B write data
- b_ready  out  1  B push accepted when b_valid&&b_ready
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- rf_src  out  1  source of current write: 0=A, 1=B
- busy_mask  out  32  bit r set while any queued FIFO entry targets register r (r!=0)

Behaviour:
- Reset (rst low, async):
  - FIFO emptied, starve counter 0.
  - rf_we, rf_waddr, rf_wdata, rf_src = 0; busy_mask = 0.
  - a_ready and b_ready forced 0 while rst is low.
- Reset mid-operation: queued B entries discarded, no write issued; first possible write is the cycle after the first post-reset grant.
- B FIFO:
  - b_ready = !full.
  - Push on b_valid&&b_ready.
  - No flow-through: an entry pushed in cycle N is eligible for grant from N+1.
  - Full with simultaneous pop: b_ready stays 0 that cycle.
- force_b = guard counter == STARVE_LIMIT && FIFO non-empty.
- a_ready = !force_b (combinational; depends on FIFO state and counter only, never on a_valid).
- Grant, evaluated once per cycle:
  - a_valid&&a_ready: grant A.
  - else FIFO non-empty: grant B, pop head.
  - else: no grant.
- Output stage, at next edge:
  - On a grant: rf_we <= (addr != 0); rf_waddr/rf_wdata/rf_src <= granted request.
  - No grant: rf_we <= 0; addr/data/src hold.
  - Latency: A = 1 cycle from acceptance. B = at least 2 cycles from push.
- Register 0 writes are accepted and consume the grant but never assert rf_we.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when A is granted while the FIFO is non-empty.
  - Clears to 0 when B is granted or the FIFO is empty.
- busy_mask:
  - Combinational OR over valid FIFO entries.
  - Bit clears in the cycle after the entry's pop edge; the write is then in the output stage and lands in the register file at the following edge.
- Ordering:
  - FIFO preserves B order.
  - A-vs-B same-address ordering is grant order.
  - WAW/RAW protection is the hazard unit's job via busy_mask.

Optional Feature:
- Macro RF_ARB_STARVE_GUARD_EN.
- Defined: starve counter and force_b as above.
- Undefined:
  - Strict A priority; counter removed; force_b = 0; a_ready = 1 outside reset.
  - B is granted only in cycles with a_valid=0.

Test Plan:
- Post-reset idle: release rst with no requests -> rf_we=0, busy_mask=0, a_ready=1, b_ready=1.
- A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_src=0.
- B latency and busy_mask:
  - Push b_addr=9, b_data=0x1234 with A idle -> busy_mask[9]=1 next cycle.
  - rf_we=1, rf_waddr=9, rf_src=1 two cycles after push; busy_mask[9]=0 on that same cycle.
- FIFO full, FIFO_DEPTH=2, A held valid, guard undefined:
  - Push 3 B writes -> b_ready=0 after 2nd push; 3rd held.
  - Drop a_valid -> B writes emerge in push order.
- Starvation, guard defined, STARVE_LIMIT=4:
  - One B entry queued, a_valid=1 continuously -> 4 A writes.
  - Then a_ready=0 for 1 cycle, then a B write, then A resumes.
- r0 and async reset:
  - A write to addr 0 -> rf_we stays 0.
  - Assert rst low mid-cycle with 2 B entries queued -> outputs 0 immediately; no B write ever appears after release.
